// File: rtl/grf_sb.sv
// grf_sb: MIPS general register file with a per-register pending-write scoreboard.
// Optional trace: define GRF_TRACE_EN to print one line per nonzero-register writeback.

module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_ready,
    output logic              rt_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ok,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [31:0]       wb_pc,
    input  logic              flush,
    output logic              sb_err
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];
    logic [NREG-1:0]   touched;
    logic              wb_write;

    assign wb_write = wb_en && (wb_addr != '0);

    // A value is final once no writer is pending, or the last pending writer is on the bypass now.
    always_comb begin
        rs_data  = '0;
        rs_ready = 1'b1;
        if (rs_addr != '0) begin
            rs_data  = (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
            rs_ready = (cnt[rs_addr] == '0) ||
                       (cnt[rs_addr] == CNT_ONE && wb_en && wb_addr == rs_addr);
        end
    end

    always_comb begin
        rt_data  = '0;
        rt_ready = 1'b1;
        if (rt_addr != '0) begin
            rt_data  = (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
            rt_ready = (cnt[rt_addr] == '0) ||
                       (cnt[rt_addr] == CNT_ONE && wb_en && wb_addr == rt_addr);
        end
    end

    // A saturated register can still take a new reservation if a writeback frees a slot this cycle.
    assign issue_ok = issue_valid &&
                      ((issue_addr == '0) ||
                       (cnt[issue_addr] != CNT_MAX) ||
                       (wb_en && wb_addr == issue_addr));

    assign cnt[0]     = '0;
    assign touched[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_reg
        logic [CNT_W-1:0] cnt_q;
        logic             touched_q;
        logic             inc;
        logic             dec;

        assign inc = issue_ok && (issue_addr == ADDR_W'(g));
        assign dec = wb_en && (wb_addr == ADDR_W'(g)) && (cnt_q != '0);

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                cnt_q     <= '0;
                touched_q <= 1'b0;
            end else begin
                if (inc && !dec)
                    cnt_q <= cnt_q + CNT_ONE;
                else if (dec && !inc)
                    cnt_q <= cnt_q - CNT_ONE;
                if (inc)
                    touched_q <= 1'b1;
            end
        end

        assign cnt[g]     = cnt_q;
        assign touched[g] = touched_q;
    end

    // Data writes ignore flush; sb_err flags a writeback with no outstanding reservation left.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs   <= '{default: '0};
            sb_err <= 1'b0;
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
            if (cnt[wb_addr] == '0 && touched[wb_addr])
                sb_err <= 1'b1;
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && wb_write)
            $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data);
    end
`else
    logic unused_wb_pc;
    assign unused_wb_pc = ^wb_pc;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed and randomized checks of grf_sb against a behavioural scoreboard model.

module tb_grf_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int NREG   = 32;
    localparam int MAXC   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rs_addr, rt_addr, issue_addr, wb_addr;
    logic [DATA_W-1:0] rs_data, rt_data, wb_data;
    logic              rs_ready, rt_ready, issue_valid, issue_ok, wb_en, flush, sb_err;
    logic [31:0]       wb_pc;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_regs [NREG];
    int          m_cnt  [NREG];
    bit          m_touched [NREG];
    bit          m_err;

    grf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_ready(rs_ready), .rt_ready(rt_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ok(issue_ok),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .flush(flush), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic bit exp_issue_ok();
        return issue_valid && (issue_addr == 0 || m_cnt[issue_addr] != MAXC ||
                               (wb_en && wb_addr == issue_addr));
    endfunction

    function automatic bit exp_ready(input logic [ADDR_W-1:0] a);
        return (a == 0) || (m_cnt[a] == 0) || (m_cnt[a] == 1 && wb_en && wb_addr == a);
    endfunction

    function automatic logic [31:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // Scoreboard model: pending writers per register as plain integers.
    task automatic model_clock();
        bit ok;
        int dec_r;
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = 0; m_cnt[i] = 0; m_touched[i] = 0;
            end
            m_err = 0;
        end else begin
            ok = exp_issue_ok();
            dec_r = -1;
            if (wb_en && wb_addr != 0) begin
                if (m_cnt[wb_addr] == 0 && m_touched[wb_addr]) m_err = 1;
                if (m_cnt[wb_addr] > 0) dec_r = int'(wb_addr);
                m_regs[wb_addr] = wb_data;
            end
            if (flush) begin
                for (int i = 0; i < NREG; i++) begin
                    m_cnt[i] = 0; m_touched[i] = 0;
                end
            end else begin
                if (dec_r >= 0) m_cnt[dec_r]--;
                if (ok && issue_addr != 0) begin
                    m_cnt[issue_addr]++;
                    m_touched[issue_addr] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) model_clock();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_addr = 0; wb_en = 0; wb_addr = 0;
        wb_data = 0; wb_pc = 0; flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; rs_addr = 0; rt_addr = 0; idle_inputs();
        tick(); tick();
        reset = 0; rs_addr = 5; rt_addr = 0;
        @(negedge clk);
        checks++; if (rs_data !== 32'h0) $display("[TB] FAIL reset_rs_data: got %h expected 0", rs_data); else passes++;
        checks++; if (rt_data !== 32'h0) $display("[TB] FAIL reset_rt_data: got %h expected 0", rt_data); else passes++;
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL reset_rs_ready: got %b expected 1", rs_ready); else passes++;
        checks++; if (rt_ready !== 1'b1) $display("[TB] FAIL reset_rt_ready: got %b expected 1", rt_ready); else passes++;
        checks++; if (sb_err !== 1'b0) $display("[TB] FAIL reset_sb_err: got %b expected 0", sb_err); else passes++;
        tick();
    endtask

    task automatic test_zero_write();
        wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; rs_addr = 0;
        @(negedge clk);
        checks++; if (rs_data !== 32'h0) $display("[TB] FAIL zero_bypass: got %h expected 0", rs_data); else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (rs_data !== 32'h0) $display("[TB] FAIL zero_read: got %h expected 0", rs_data); else passes++;
        tick();
    endtask

    task automatic test_single_issue();
        issue_valid = 1; issue_addr = 8; rs_addr = 8;
        @(negedge clk);
        checks++; if (issue_ok !== 1'b1) $display("[TB] FAIL issue8_ok: got %b expected 1", issue_ok); else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (rs_ready !== 1'b0) $display("[TB] FAIL issue8_pending: got %b expected 0", rs_ready); else passes++;
        #1 wb_en = 1; wb_addr = 8; wb_data = 32'h1234;
        #1;
        checks++; if (rs_data !== 32'h1234) $display("[TB] FAIL wb8_bypass_data: got %h expected 1234", rs_data); else passes++;
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL wb8_bypass_ready: got %b expected 1", rs_ready); else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (rs_data !== 32'h1234) $display("[TB] FAIL wb8_stored: got %h expected 1234", rs_data); else passes++;
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL wb8_released: got %b expected 1", rs_ready); else passes++;
        tick();
    endtask

    task automatic test_saturate();
        rs_addr = 9;
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; issue_addr = 9;
            @(negedge clk);
            checks++; if (issue_ok !== 1'b1) $display("[TB] FAIL sat_issue%0d: got %b expected 1", k, issue_ok); else passes++;
            tick();
        end
        @(negedge clk);
        checks++; if (issue_ok !== 1'b0) $display("[TB] FAIL sat_refused: got %b expected 0", issue_ok); else passes++;
        tick();
        wb_en = 1; wb_addr = 9; wb_data = $urandom;
        @(negedge clk);
        checks++; if (issue_ok !== 1'b1) $display("[TB] FAIL sat_issue_with_wb: got %b expected 1", issue_ok); else passes++;
        tick();
        idle_inputs();
        // Three writebacks are needed to drain: only the third sees a final bypassed value.
        for (int k = 0; k < 3; k++) begin
            wb_en = 1; wb_addr = 9; wb_data = $urandom;
            @(negedge clk);
            checks++; if (rs_ready !== (k == 2)) $display("[TB] FAIL sat_drain%0d: got %b expected %b", k, rs_ready, k == 2); else passes++;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL sat_drained: got %b expected 1", rs_ready); else passes++;
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] d;
        issue_valid = 1; issue_addr = 10;
        tick(); tick();
        issue_addr = 11; flush = 1;
        @(negedge clk);
        checks++; if (issue_ok !== 1'b1) $display("[TB] FAIL flush_issue_ok: got %b expected 1", issue_ok); else passes++;
        tick();
        idle_inputs(); rs_addr = 10; rt_addr = 11;
        @(negedge clk);
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL flush_ready10: got %b expected 1", rs_ready); else passes++;
        checks++; if (rt_ready !== 1'b1) $display("[TB] FAIL flush_ready11: got %b expected 1", rt_ready); else passes++;
        d = $urandom;
        wb_en = 1; wb_addr = 10; wb_data = d;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (sb_err !== 1'b0) $display("[TB] FAIL flush_no_err: got %b expected 0", sb_err); else passes++;
        checks++; if (rs_data !== d) $display("[TB] FAIL flush_wb_data: got %h expected %h", rs_data, d); else passes++;
        tick();
    endtask

    task automatic test_sb_err();
        logic [31:0] d;
        issue_valid = 1; issue_addr = 12; rs_addr = 12;
        tick();
        idle_inputs(); wb_en = 1; wb_addr = 12; wb_data = $urandom;
        tick();
        d = $urandom; wb_data = d;
        @(negedge clk);
        checks++; if (sb_err !== 1'b0) $display("[TB] FAIL err_before: got %b expected 0", sb_err); else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (sb_err !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", sb_err); else passes++;
        checks++; if (rs_data !== d) $display("[TB] FAIL err_data: got %h expected %h", rs_data, d); else passes++;
        tick(); tick(); flush = 1; tick(); flush = 0;
        @(negedge clk);
        checks++; if (sb_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", sb_err); else passes++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rs_addr = ADDR_W'($urandom_range(0, 7));
            rt_addr = ADDR_W'($urandom_range(0, 7));
            issue_valid = $urandom_range(0, 1) == 1;
            issue_addr = ADDR_W'($urandom_range(0, 7));
            wb_en = $urandom_range(0, 1) == 1;
            wb_addr = ADDR_W'($urandom_range(0, 7));
            wb_data = $urandom;
            wb_pc = $urandom;
            flush = $urandom_range(0, 31) == 0;
            @(negedge clk);
            checks++; if (rs_data !== exp_read(rs_addr)) $display("[TB] FAIL rnd_rs_data@%0d: got %h expected %h", n, rs_data, exp_read(rs_addr)); else passes++;
            checks++; if (rt_data !== exp_read(rt_addr)) $display("[TB] FAIL rnd_rt_data@%0d: got %h expected %h", n, rt_data, exp_read(rt_addr)); else passes++;
            checks++; if (rs_ready !== exp_ready(rs_addr)) $display("[TB] FAIL rnd_rs_ready@%0d: got %b expected %b", n, rs_ready, exp_ready(rs_addr)); else passes++;
            checks++; if (rt_ready !== exp_ready(rt_addr)) $display("[TB] FAIL rnd_rt_ready@%0d: got %b expected %b", n, rt_ready, exp_ready(rt_addr)); else passes++;
            checks++; if (issue_ok !== exp_issue_ok()) $display("[TB] FAIL rnd_issue_ok@%0d: got %b expected %b", n, issue_ok, exp_issue_ok()); else passes++;
            checks++; if (sb_err !== m_err) $display("[TB] FAIL rnd_sb_err@%0d: got %b expected %b", n, sb_err, m_err); else passes++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_addr = 3; wb_en = 1; wb_addr = 3; wb_data = 32'hCAFEF00D;
        flush = 1; reset = 1;
        tick();
        reset = 0; idle_inputs(); rs_addr = 3; rt_addr = 9;
        @(negedge clk);
        checks++; if (rs_data !== 32'h0) $display("[TB] FAIL rmid_rs_data: got %h expected 0", rs_data); else passes++;
        checks++; if (rt_data !== 32'h0) $display("[TB] FAIL rmid_rt_data: got %h expected 0", rt_data); else passes++;
        checks++; if (rs_ready !== 1'b1) $display("[TB] FAIL rmid_rs_ready: got %b expected 1", rs_ready); else passes++;
        checks++; if (sb_err !== 1'b0) $display("[TB] FAIL rmid_sb_err: got %b expected 0", sb_err); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_write();
        test_single_issue();
        test_saturate();
        test_flush();
        test_sb_err();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised general register file for the pipelined MIPS core, with a per-register pending-write scoreboard.
- Sits in the D stage. Supplies two read operands with same-cycle writeback bypass.
- The issue side reserves a destination register; the W stage writes it back and releases the reservation.
- Ready flags let hazard logic stall on registers whose producer has not written back, replacing stage-by-stage comparison of destination addresses.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; NREG = 2**ADDR_W entries; entry 0 hardwired to zero.
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2**CNT_W - 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rs_addr  in  ADDR_W  read port 1 address.
- rt_addr  in  ADDR_W  read port 2 address.
- rs_data  out  DATA_W  read port 1 data.
- rt_data  out  DATA_W  read port 2 data.
- rs_ready  out  1  read port 1 value is final.
- rt_ready  out  1  read port 2 value is final.
- issue_valid  in  1  request to reserve issue_addr.
- issue_addr  in  ADDR_W  destination being issued.
- issue_ok  out  1  reservation accepted this cycle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- wb_pc  in  32  PC of the writing instruction; trace only.
- flush  in  1  drop all reservations (exception or eret).
- sb_err  out  1  sticky: writeback to a nonzero register with counter 0 while a reservation existed elsewhere is allowed; this flag instead marks a counter decrement attempted at 0 on a register reserved earlier since reset/flush (see Behaviour).

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - All NREG data entries become 0.
  - All counters become 0.
  - sb_err becomes 0.
  - Outputs after reset: rs_data = rt_data = 0, rs_ready = rt_ready = 1.
- Writes:
  - On posedge clk, if wb_en and wb_addr != 0, entry[wb_addr] <= wb_data.
  - Writes to address 0 are discarded.
- Reads (combinational, zero latency):
  - Address 0 returns 0.
  - Else if wb_en and wb_addr == rd_addr, the port returns wb_data (write-through bypass).
  - Else the port returns entry[rd_addr].
- Counters, one per register 1..NREG-1; register 0 has none and is always ready.
  - inc = issue_ok && issue_addr == r.
  - dec = wb_en && wb_addr == r && cnt[r] != 0.
  - inc && dec: unchanged. inc only: +1. dec only: -1.
  - wb_en to a register with cnt == 0: the data write still happens and the counter stays 0.
  - sb_err sets only if that register had been reserved since the last reset/flush (track with a one-bit "touched" flag per register, cleared by reset/flush).
- issue_ok = issue_valid && (issue_addr == 0 || cnt[issue_addr] != MAX || (wb_en && wb_addr == issue_addr)).
  - issue_addr == 0 is accepted with no effect.
  - A saturated issue is refused. Upstream must stall; the block records nothing.
- rs_ready (rt_ready alike) is 1 when any of:
  - addr == 0;
  - cnt[addr] == 0;
  - cnt[addr] == 1 && wb_en && wb_addr == addr (the bypassed value is final).
- flush:
  - Next cycle all counters and touched flags are 0.
  - flush takes priority over a same-cycle issue: the reservation is lost and issue_ok still reflects the pre-flush rule.
  - A same-cycle writeback data write still happens.
- Reset mid-operation overrides flush, issue and writeback.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on each accepted write with wb_addr != 0, $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data) at the clock edge. Writes to $0 print nothing.
- Undefined: no display; wb_pc is unused. Functional behaviour is identical either way.

Test Plan:
- Reset, then read rs_addr = 5, rt_addr = 0 -> rs_data = 0, rt_data = 0, both ready = 1.
- wb_en = 1, wb_addr = 0, wb_data = 32'hDEADBEEF, then read 0 -> rs_data = 0. With GRF_TRACE_EN, no line printed.
- Issue $8 (cnt 0->1) -> rs_addr = 8 gives rs_ready = 0.
  - Next cycle wb $8 = 32'h1234 with rs_addr = 8 -> rs_data = 32'h1234, rs_ready = 1 in the same cycle.
  - Following cycle: cnt = 0, entry[8] = 32'h1234.
- Issue $9 three times (CNT_W = 2, cnt = 3) -> fourth issue_valid gives issue_ok = 0 and cnt stays 3.
  - Same cycle with wb $9 instead -> issue_ok = 1 and cnt stays 3.
- Issue $10 twice, then flush and issue $11 in the same cycle -> next cycle all ready = 1 and cnt[11] = 0.
  - A later wb to $10 writes data and leaves sb_err = 0 (touched flags were cleared).
- Issue $12, wb $12 (cnt 0), then wb $12 again -> sb_err = 1 and stays 1 until reset.
